stopwatch_core: RTL

//   Time-keeping stage directly downstream of clk_divider. Takes its divided output (100 Hz)
//   as a data input, never as a clock: synchronises and edge-detects it in the clk100MHz

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/bcd_digit_counter.sv | 30 +++
 rtl/stopwatch_core.sv | 118 +++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch datapath: FSM state encoding and the BCD digit type.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..MAX on inc and flags a combinational carry on the
// increment that wraps it back to 0.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = BCD_MAX
) (
    input  logic clk100MHz,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t digit,
    output logic carry
);

    bcd_t r_digit;

    // Anything at or above MAX wraps to 0, so a corrupted digit heals on its next increment.
    always_ff @(posedge clk100MHz) begin
        if (rst || clr) begin
            r_digit <= '0;
        end else if (inc) begin
            r_digit <= (r_digit >= MAX) ? 4'd0 : r_digit + 4'd1;
        end
    end

    assign digit = r_digit;
    assign carry = inc & (r_digit == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: synchronises the 100 Hz tick, runs the start/pause/clear FSM and
// keeps an SS.hh BCD count with a one-cycle wrap pulse on 59.99 -> 00.00.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter bcd_t        SEC_TENS_MAX = 4'd5
) (
    input  logic clk100MHz,
    input  logic rst,
    input  logic tick_in,
    input  logic start_stop,
    input  logic clear,
    output logic running,
    output bcd_t hund_u,
    output bcd_t hund_t,
    output bcd_t sec_u,
    output bcd_t sec_t,
    output logic wrap
);

    logic [SYNC_STAGES-1:0] r_tick_sync;
    logic                   r_tick_dly;
    logic                   r_ss_q;
    logic                   r_clr_q;
    logic                   r_wrap;
    sw_state_t              r_state;
    sw_state_t              w_state_next;

    logic w_tick_pulse;
    logic w_ss_rise;
    logic w_clr_rise;
    logic w_inc;
    logic w_carry_hu;
    logic w_carry_ht;
    logic w_carry_su;
    logic w_carry_st;

    // tick_in is a divided clock used purely as data; sample it like any async input.
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            r_tick_sync <= '0;
            r_tick_dly  <= 1'b0;
            r_ss_q      <= 1'b0;
            r_clr_q     <= 1'b0;
            r_wrap      <= 1'b0;
            r_state     <= IDLE;
        end else begin
            r_tick_sync <= {r_tick_sync[SYNC_STAGES-2:0], tick_in};
            r_tick_dly  <= r_tick_sync[SYNC_STAGES-1];
            r_ss_q      <= start_stop;
            r_clr_q     <= clear;
            r_wrap      <= w_carry_st;
            r_state     <= w_state_next;
        end
    end

    assign w_tick_pulse = r_tick_sync[SYNC_STAGES-1] & ~r_tick_dly;
    assign w_ss_rise    = start_stop & ~r_ss_q;
    assign w_clr_rise   = clear & ~r_clr_q;

    always_comb begin
        w_state_next = r_state;
        if (w_clr_rise) begin
            w_state_next = IDLE;
        end else if (w_ss_rise) begin
            unique case (r_state)
                IDLE:    w_state_next = RUN;
                RUN:     w_state_next = PAUSE;
                PAUSE:   w_state_next = RUN;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Gate on the registered state: the tick landing on RUN->PAUSE counts, on ->RUN does not.
    assign w_inc = w_tick_pulse & (r_state == RUN) & ~w_clr_rise;

    bcd_digit_counter #(.MAX(BCD_MAX)) u_hund_u (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .clr       (w_clr_rise),
        .inc       (w_inc),
        .digit     (hund_u),
        .carry     (w_carry_hu)
    );

    bcd_digit_counter #(.MAX(BCD_MAX)) u_hund_t (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .clr       (w_clr_rise),
        .inc       (w_carry_hu),
        .digit     (hund_t),
        .carry     (w_carry_ht)
    );

    bcd_digit_counter #(.MAX(BCD_MAX)) u_sec_u (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .clr       (w_clr_rise),
        .inc       (w_carry_ht),
        .digit     (sec_u),
        .carry     (w_carry_su)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_t (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .clr       (w_clr_rise),
        .inc       (w_carry_su),
        .digit     (sec_t),
        .carry     (w_carry_st)
    );

    assign running = (r_state == RUN);
    assign wrap    = r_wrap;

endmodule
